// File: rtl/fifo_drain_serializer_if.sv
// Handshake bundle between a FIFO read port, the drain serializer and its serial pin.
// The serializer uses the slave modport; the environment driving the FIFO side uses master.
interface fifo_drain_serializer_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             empty;
    logic [WIDTH-1:0] read;
    logic             pop;
    logic             tx;
    logic             busy;
    logic             word_done;
    logic [15:0]      frame_count;

    modport slave (
        input  enable, empty, read,
        output pop, tx, busy, word_done, frame_count
    );

    modport master (
        output enable, empty, read,
        input  pop, tx, busy, word_done, frame_count
    );
endinterface

// File: rtl/fifo_drain_serializer.sv
// Pops words from a FIFO and sends each as start bit, WIDTH data bits LSB first, stop bit.
// Back-to-back frames relaunch from the last stop cycle, so there is no idle gap between them.
module fifo_drain_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    fifo_drain_serializer_if.slave  io
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cycle_q, cycle_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shiftNext;
    logic             tx_q, tx_d;
    logic [15:0]      frameCount_q, frameCount_d;
    logic             lastCycle;
    logic             stopEnd;
    logic             pop;

    assign lastCycle = (cycle_q == CW'(CLKS_PER_BIT - 1));
    assign stopEnd   = (state_q == STOP) && lastCycle;
    assign shiftNext = shift_q >> 1;

    // rstn gates pop so the FIFO is never drained while the block is held in reset.
    assign pop = rstn && io.enable && !io.empty && ((state_q == IDLE) || stopEnd);

    assign io.pop         = pop;
    assign io.tx          = tx_q;
    assign io.busy        = (state_q != IDLE);
    assign io.word_done   = stopEnd;
    assign io.frame_count = frameCount_q;

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q + CW'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        frameCount_d = stopEnd ? frameCount_q + 16'd1 : frameCount_q;

        case (state_q)
            IDLE: begin
                cycle_d = '0;
                if (pop) begin
                    state_d = START;
                    shift_d = io.read;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (lastCycle) begin
                    state_d = DATA;
                    cycle_d = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (lastCycle) begin
                    cycle_d = '0;
                    shift_d = shiftNext;
                    if (bit_q == BW'(WIDTH - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + BW'(1);
                        tx_d  = shiftNext[0];
                    end
                end
            end
            STOP: begin
                if (lastCycle) begin
                    cycle_d = '0;
                    if (pop) begin
                        state_d = START;
                        shift_d = io.read;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cycle_d = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cycle_q      <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            frameCount_q <= '0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            frameCount_q <= frameCount_d;
        end
    end
endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: a queue stands in for the FIFO and a frame-position
// model predicts pop, tx, busy, word_done and frame_count on every cycle.
module tb_fifo_drain_serializer;
    localparam int WIDTH = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (WIDTH + 2) * CPB;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    fifo_drain_serializer_if #(.WIDTH(WIDTH)) bus ();

    fifo_drain_serializer #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (bus.slave)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [WIDTH-1:0] fifoQ[$];
    bit               mActive = 1'b0;
    int               mPos    = 0;
    logic [WIDTH+1:0] mBits   = '1;
    int               mCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    // The FIFO head is only meaningful when non-empty; otherwise present junk to prove it is ignored.
    task automatic driveFifo();
        bus.empty = (fifoQ.size() == 0);
        bus.read  = (fifoQ.size() != 0) ? fifoQ[0] : WIDTH'($urandom);
    endtask

    task automatic stepCycle();
        bit expPop;
        bit lastStop;
        @(negedge clk);
        lastStop = mActive && (mPos == FRAME - 1);
        expPop   = rstn && bus.enable && (fifoQ.size() != 0) && (!mActive || lastStop);
        checkOutput("pop",         32'(bus.pop),       32'(expPop));
        checkOutput("tx",          32'(bus.tx),        mActive ? 32'(mBits[mPos / CPB]) : 32'd1);
        checkOutput("busy",        32'(bus.busy),      32'(mActive));
        checkOutput("word_done",   32'(bus.word_done), 32'(lastStop));
        checkOutput("frame_count", 32'(bus.frame_count), 32'(mCount[15:0]));
        @(posedge clk);
        if (lastStop) mCount = (mCount + 1) % 65536;
        if (expPop) begin
            mBits   = {1'b1, fifoQ[0], 1'b0};
            mActive = 1'b1;
            mPos    = 0;
            void'(fifoQ.pop_front());
        end else if (mActive) begin
            if (lastStop) mActive = 1'b0;
            else          mPos++;
        end
        #1;
        driveFifo();
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) stepCycle();
    endtask

    task automatic asyncReset();
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst_tx",        32'(bus.tx),          32'd1);
        checkOutput("rst_busy",      32'(bus.busy),        32'd0);
        checkOutput("rst_pop",       32'(bus.pop),         32'd0);
        checkOutput("rst_word_done", 32'(bus.word_done),   32'd0);
        checkOutput("rst_count",     32'(bus.frame_count), 32'd0);
        mActive = 1'b0;
        mCount  = 0;
    endtask

    task automatic runToLastStop(input string tag);
        int guard;
        guard = 0;
        while (!(mActive && mPos == FRAME - 1) && guard < 4 * FRAME) begin
            stepCycle();
            guard++;
        end
        checkOutput(tag, 32'(guard < 4 * FRAME), 32'd1);
    endtask

    initial begin
        bus.enable = 1'b1;
        fifoQ.push_back(8'h11);
        driveFifo();

        // Reset held with a non-empty FIFO: nothing may move.
        applyStimulus(6);
        fifoQ.delete();
        fifoQ.push_back(8'hA5);
        driveFifo();
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single word 0xA5.
        applyStimulus(FRAME + 6);
        checkOutput("single_count", 32'(bus.frame_count), 32'd1);

        // Back-to-back 0x00 then 0xFF.
        fifoQ.push_back(8'h00);
        fifoQ.push_back(8'hFF);
        driveFifo();
        applyStimulus(2 * FRAME + 6);
        checkOutput("b2b_count", 32'(bus.frame_count), 32'd3);
        checkOutput("b2b_idle_tx", 32'(bus.tx), 32'd1);

        // Enable gating, then drop enable mid-DATA with more words waiting.
        bus.enable = 1'b0;
        fifoQ.push_back(8'h5A);
        fifoQ.push_back(8'hC3);
        driveFifo();
        applyStimulus(20);
        bus.enable = 1'b1;
        applyStimulus(3 * CPB);
        bus.enable = 1'b0;
        applyStimulus(FRAME + 10);
        checkOutput("gate_count", 32'(bus.frame_count), 32'd4);
        bus.enable = 1'b1;
        applyStimulus(FRAME + 4);

        // Asynchronous reset during bit 3 of 0x3C.
        fifoQ.push_back(8'h3C);
        driveFifo();
        for (int g = 0; g < 4 * FRAME && !(mActive && mPos == CPB * 4 + 1); g++) stepCycle();
        checkOutput("reach_bit3", 32'(bus.busy), 32'd1);
        asyncReset();
        applyStimulus(3);
        @(posedge clk);
        #1 rstn = 1'b1;
        applyStimulus(10);
        checkOutput("post_rst_count", 32'(bus.frame_count), 32'd0);

        // Stop-cycle race: a word appears exactly on the last stop cycle.
        fifoQ.push_back(8'h96);
        driveFifo();
        runToLastStop("reach_stop1");
        fifoQ.push_back(8'h69);
        driveFifo();
        stepCycle();
        applyStimulus(1);
        checkOutput("race_start", 32'(bus.tx), 32'd0);
        runToLastStop("reach_stop2");
        stepCycle();
        applyStimulus(1);
        checkOutput("race_idle", 32'(bus.busy), 32'd0);

        // Randomized traffic with occasional enable drops and resets.
        for (int i = 0; i < 3000; i++) begin
            bus.enable = ($urandom_range(0, 9) != 0);
            if (fifoQ.size() < 4 && $urandom_range(0, 7) == 0) fifoQ.push_back(WIDTH'($urandom));
            driveFifo();
            if ($urandom_range(0, 999) == 0) begin
                asyncReset();
                applyStimulus(2);
                @(posedge clk);
                #1 rstn = 1'b1;
            end
            stepCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
- Consumer-side companion to the team's push/pop FIFO.
- Pops WIDTH-bit words through the FIFO's `pop`/`empty`/`read` read port.
- Sends each word on a single-wire asynchronous serial line: start bit, WIDTH data bits LSB first, stop bit, at a fixed clocks-per-bit rate.
- Sits between a FIFO instance and an off-block serial pin.

Parameters:
- WIDTH, 8, data word width; must match the feeding FIFO's WIDTH.
- CLKS_PER_BIT, 16, clock cycles per serial bit period; legal range 2..65535.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  asynchronous active-low reset.
- enable  input  1  when 1, the block may start new frames.
- empty  input  1  FIFO empty flag.
- read  input  WIDTH  FIFO head word; valid whenever empty=0.
- pop  output  1  FIFO pop strobe; at most one cycle per word.
- tx  output  1  serial line; idle level 1.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- word_done  output  1  one-cycle pulse in the final cycle of each stop bit.
- frame_count  output  16  number of completed frames; wraps 65535 -> 0.

Behaviour:
- Reset (rstn=0, async, takes effect immediately):
  - state=IDLE; tx=1, busy=0, word_done=0, frame_count=0.
  - Bit counter and shift register cleared.
  - pop is forced to 0 while rstn=0.
- FSM states and tx level:
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: WIDTH bits, each held CLKS_PER_BIT cycles, shift_reg[0] first, shift right after each bit.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- Timing counters:
  - Cycle counter: $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1 and resets to 0 on every state or bit change.
  - Bit index: $clog2(WIDTH)+1 bits.
- Pop condition (combinational):
  - pop = enable & ~empty & (state==IDLE | (state==STOP & cycle counter==CLKS_PER_BIT-1)).
  - On the clock edge where pop=1: shift_reg <= read, state <= START.
  - Never pop when empty=1. Never pop outside the two launch points above.
- Output timing:
  - tx is registered. It changes on the edge that enters a state or bit, so tx falls one cycle after the pop cycle.
  - Frame length is exactly (WIDTH+2)*CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the last stop cycle.
- End of stop bit:
  - word_done=1 for that one cycle; frame_count increments (registered, visible next cycle).
  - If pop is also asserted that cycle, the next state is START: back-to-back frames with no idle gap.
  - Otherwise the next state is IDLE.
- enable deasserted mid-frame: the current frame completes unchanged; no further pop until enable=1.
- empty rising mid-frame: no effect on the current frame; the block returns to IDLE after STOP.
- Changes to read while not popping: ignored; the shift register is the only data source during a frame.
- Reset mid-frame: tx returns to 1 immediately. The popped word is discarded; it is not re-popped.
- pop may be combinational from empty/enable; this is allowed because the FIFO's empty/read are combinational from its registers (no loop).

Test Plan:
- Reset: hold rstn=0 with empty=0, enable=1 -> tx=1, pop=0, busy=0, word_done=0, frame_count=0 throughout.
- Single word, WIDTH=8, CLKS_PER_BIT=4, read=8'hA5, empty=0 for one pop then 1:
  - pop high exactly 1 cycle.
  - tx sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1 (40 cycles total).
  - word_done pulses once, on the last stop cycle; frame_count=1; then IDLE with tx=1.
- Back-to-back, FIFO holds 8'h00 then 8'hFF:
  - Second start bit begins the cycle after the first frame's last stop cycle (no gap).
  - Exactly 2 pops; frame_count=2; tx stays 1 after the second stop bit.
- Enable gating, empty=0, enable=0 for 20 cycles -> no pop, tx=1.
  - Then enable=1 -> pop next cycle.
  - Deassert enable during DATA -> frame finishes, no second pop while the FIFO is still non-empty.
- Async reset mid-DATA (bit 3 of 8'h3C) -> tx=1 and busy=0 the same cycle with no clock edge required.
  - After release with empty=1: stays IDLE, frame_count=0, no pop.
- Stop-cycle race: empty goes 0 exactly on the final stop cycle of a frame -> pop asserted that cycle and START entered with no idle gap.
  - Same case with empty=1 -> IDLE entered, pop=0.
